// File: rtl/load_store_ctrl.sv
// Purpose : sequences one data-memory load/store at a time, building byte enables and lane-replicated write data.
// Latency : accept at N, gnt at N+1, rvalid at N+2 -> rsp_valid at N+3; illegal accesses respond at N+1.
// Backpressure: lsu_ready is high only in IDLE; mem_req is held until mem_gnt, or until the access times out.
//
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   lsu_valid/lsu_ready              pipeline request handshake
//   lsu_we/lsu_funct3/lsu_addr/lsu_wdata   access description (RV32I funct3 encoding)
//   mem_req/mem_gnt                  memory request handshake
//   mem_addr/mem_we/mem_be/mem_wdata request payload, driven only while requesting
//   mem_rvalid/mem_rdata             read data / write ack
//   ld_ctrl/ld_data                  {funct3, addr[1:0]} and raw read word for the load-extend block
//   rsp_valid/rsp_err                one-cycle completion pulse, err = misaligned/illegal or timeout
module load_store_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  ld_ctrl,
  output logic [31:0] ld_data,
  output logic        rsp_valid,
  output logic        rsp_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     funct3_q, funct3_d;
  logic [31:0]    addr_q, addr_d;
  logic           we_q, we_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    ld_data_q, ld_data_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cnt_inc;

  logic           acc_misaligned;
  logic           acc_bad_funct3;
  logic           acc_illegal;
  logic [3:0]     be_w;
  logic [31:0]    wdata_w;
  logic           in_req;

  // Legality of the incoming request, evaluated on the raw inputs at accept.
  always_comb begin
    acc_misaligned = 1'b0;
    case (lsu_funct3[1:0])
      2'b01:   acc_misaligned = lsu_addr[0];
      2'b10:   acc_misaligned = |lsu_addr[1:0];
      default: acc_misaligned = 1'b0;
    endcase
    if (lsu_we) begin
      acc_bad_funct3 = (lsu_funct3 > 3'b010);
    end else begin
      acc_bad_funct3 = (lsu_funct3 == 3'b011) || (lsu_funct3[2:1] == 2'b11);
    end
    acc_illegal = acc_misaligned || acc_bad_funct3;
  end

  // Byte enables and write data from the captured request. Only legal
  // widths reach REQ, so funct3[1:0]==2'b11 never needs a lane pattern.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be_w    = 4'b0001 << addr_q[1:0];
        wdata_w = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_w    = 4'b0011 << addr_q[1:0];
        wdata_w = {2{wdata_q[15:0]}};
      end
      default: begin
        be_w    = 4'b1111;
        wdata_w = wdata_q;
      end
    endcase
  end

  // The timeout fires when the post-increment count reaches the limit; with
  // an immediate grant this lands RESP exactly TIMEOUT_CYCLES after REQ entry,
  // since the grant cycle itself restarts the count.
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    ld_data_d = ld_data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (lsu_valid) begin
          funct3_d = lsu_funct3;
          addr_d   = lsu_addr;
          we_d     = lsu_we;
          wdata_d  = lsu_wdata;
          err_d    = acc_illegal;
          cnt_d    = '0;
          state_d  = acc_illegal ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if (cnt_inc == CNT_LIM) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (!we_q) begin
            ld_data_d = mem_rdata;
          end
          state_d = S_RESP;
        end else if (cnt_inc == CNT_LIM) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      funct3_q  <= 3'b000;
      addr_q    <= 32'h0;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      ld_data_q <= 32'h0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Request payload is only presented while requesting so that the bus
  // idles at zero and never shows stale lanes.
  assign in_req    = (state_q == S_REQ);
  assign lsu_ready = (state_q == S_IDLE);
  assign mem_req   = in_req;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_we    = in_req & we_q;
  assign mem_be    = in_req ? be_w : 4'b0000;
  assign mem_wdata = in_req ? wdata_w : 32'h0;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) & err_q;
  assign ld_ctrl   = {funct3_q, addr_q[1:0]};
  assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Purpose : self-checking bench for load_store_ctrl; responses are matched against a queue of expected completions.
// Latency : stimulus is cycle-exact; inputs change 1ns after the rising edge, outputs are checked there or on the falling edge.
// Backpressure: the bench plays the memory, withholding gnt/rvalid to exercise stalls and the timeout.
module tb_load_store_ctrl;

  logic        clk;
  logic        rst_n;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  ld_ctrl;
  logic [31:0] ld_data;
  logic        rsp_valid;
  logic        rsp_err;

  typedef struct packed {
    logic        err;
    logic [4:0]  ctrl;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb_q[$];
  rsp_t        mon_exp;
  int          errors;
  int          checks;
  logic [31:0] exp_data;

  load_store_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_we     (lsu_we),
    .lsu_funct3 (lsu_funct3),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ld_ctrl    (ld_ctrl),
    .ld_data    (ld_data),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every completion must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: rsp err=%b ctrl=%b data=%h, none expected", rsp_err, ld_ctrl, ld_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({rsp_err, ld_ctrl, ld_data} !== mon_exp) begin
          errors++;
          $display("FAIL sb_rsp: got err=%b ctrl=%b data=%h, want err=%b ctrl=%b data=%h",
                   rsp_err, ld_ctrl, ld_data, mon_exp.err, mon_exp.ctrl, mon_exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
    lsu_valid  = 1'b1;
    lsu_we     = we;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wd;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({lsu_ready, mem_req, mem_we, rsp_valid, rsp_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/req/we/rv/err=%b want 10000", {lsu_ready, mem_req, mem_we, rsp_valid, rsp_err});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || ld_ctrl !== 5'h0 || ld_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h be=%b wd=%h ctrl=%b ld=%h want all 0", mem_addr, mem_be, mem_wdata, ld_ctrl, ld_data);
    end
  endtask

  task automatic test_load_word();
    drive_req(1'b0, 3'b010, 32'h100, 32'h0);
    checks++;
    if (lsu_ready !== 1'b1) begin errors++; $display("FAIL lw_ready: %b want 1", lsu_ready); end
    sb_q.push_back({1'b0, 5'b01000, 32'hDEADBEEF});
    tick();
    lsu_valid = 1'b0;
    checks++;
    if ({mem_req, mem_we, mem_be} !== 6'b101111 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL lw_req: req=%b we=%b be=%b addr=%h want 1 0 1111 00000100", mem_req, mem_we, mem_be, mem_addr);
    end
    checks++;
    if (ld_ctrl !== 5'b01000 || lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL lw_ctrl: ld_ctrl=%b ready=%b want 01000 0", ld_ctrl, lsu_ready);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_wait: req=%b rv=%b want 0 0", mem_req, rsp_valid);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || ld_data !== 32'hDEADBEEF || ld_ctrl !== 5'b01000) begin
      errors++;
      $display("FAIL lw_rsp: rv=%b err=%b ld=%h ctrl=%b want 1 0 deadbeef 01000", rsp_valid, rsp_err, ld_data, ld_ctrl);
    end
    exp_data = 32'hDEADBEEF;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL lw_idle: rv=%b ready=%b want 0 1", rsp_valid, lsu_ready);
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s   [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] addrs [3] = '{32'h203, 32'h202, 32'h104};
    logic [31:0] wds   [3] = '{32'h000000A5, 32'h1234ABCD, 32'hCAFE0001};
    logic [31:0] eaddr [3] = '{32'h200, 32'h200, 32'h104};
    logic [3:0]  ebe   [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] ewd   [3] = '{32'hA5A5A5A5, 32'hABCDABCD, 32'hCAFE0001};
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, f3s[i], addrs[i], wds[i]);
      sb_q.push_back({1'b0, f3s[i], addrs[i][1:0], exp_data});
      tick();
      lsu_valid = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== eaddr[i] || mem_be !== ebe[i] || mem_wdata !== ewd[i]) begin
        errors++;
        $display("FAIL st_req[%0d]: req=%b we=%b addr=%h be=%b wd=%h want 1 1 %h %b %h",
                 i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, eaddr[i], ebe[i], ewd[i]);
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555AAAA;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10 || ld_data !== exp_data) begin
        errors++;
        $display("FAIL st_rsp[%0d]: rv=%b err=%b ld=%h want 1 0 %h", i, rsp_valid, rsp_err, ld_data, exp_data);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic        wes   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s   [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
    logic [31:0] addrs [5] = '{32'h101, 32'h102, 32'h100, 32'h100, 32'h101};
    for (int i = 0; i < 5; i++) begin
      drive_req(wes[i], f3s[i], addrs[i], 32'hFFFFFFFF);
      sb_q.push_back({1'b1, f3s[i], addrs[i][1:0], exp_data});
      tick();
      lsu_valid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, mem_req} !== 3'b110) begin
        errors++;
        $display("FAIL ill_rsp[%0d]: rv=%b err=%b req=%b want 1 1 0", i, rsp_valid, rsp_err, mem_req);
      end
      tick();
      checks++;
      if ({rsp_valid, mem_req, lsu_ready} !== 3'b001) begin
        errors++;
        $display("FAIL ill_idle[%0d]: rv=%b req=%b ready=%b want 0 0 1", i, rsp_valid, mem_req, lsu_ready);
      end
    end
  endtask

  task automatic test_gnt_stall();
    drive_req(1'b0, 3'b100, 32'h302, 32'h0);
    sb_q.push_back({1'b0, 5'b10010, 32'hCAFEF00D});
    tick();
    lsu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_be !== 4'b0100 || ld_ctrl !== 5'b10010) begin
        errors++;
        $display("FAIL stall_req[%0d]: req=%b addr=%h be=%b ctrl=%b want 1 00000300 0100 10010",
                 i, mem_req, mem_addr, mem_be, ld_ctrl);
      end
      tick();
    end
    // rvalid alongside gnt must be ignored.
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_samecycle: req=%b rv=%b want 0 0", mem_req, rsp_valid);
    end
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || ld_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL stall_rsp: rv=%b err=%b ld=%h want 1 0 cafef00d", rsp_valid, rsp_err, ld_data);
    end
    exp_data = 32'hCAFEF00D;
    tick();
  endtask

  task automatic test_timeout();
    drive_req(1'b0, 3'b010, 32'h400, 32'h0);
    sb_q.push_back({1'b1, 5'b01000, exp_data});
    tick();
    lsu_valid = 1'b0;
    // REQ entry cycle: grant immediately, then never answer.
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL to_early[%0d]: rv=%b req=%b want 0 0", k, rsp_valid, mem_req);
      end
      tick();
    end
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b11) begin
      errors++;
      $display("FAIL to_rsp: rv=%b err=%b want 1 1 at REQ+16", rsp_valid, rsp_err);
    end
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h99999999;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if (ld_data !== exp_data || rsp_valid !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_late_rvalid: ld=%h rv=%b ready=%b want %h 0 1", ld_data, rsp_valid, lsu_ready, exp_data);
    end
  endtask

  task automatic test_reset_mid();
    drive_req(1'b0, 3'b010, 32'h500, 32'h0);
    tick();
    lsu_valid = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    #1;
    checks++;
    if ({lsu_ready, mem_req, rsp_valid, rsp_err} !== 4'b1000 || ld_ctrl !== 5'h0 || ld_data !== 32'h0 || mem_be !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid: ready/req/rv/err=%b ctrl=%b ld=%h be=%b want 1000 0 0 0",
               {lsu_ready, mem_req, rsp_valid, rsp_err}, ld_ctrl, ld_data, mem_be);
    end
    tick();
    mem_rvalid = 1'b0;
    tick();
    rst_n    = 1'b1;
    exp_data = 32'h0;
    tick();
    drive_req(1'b0, 3'b010, 32'h104, 32'h0);
    sb_q.push_back({1'b0, 5'b01000, 32'h0BADF00D});
    tick();
    lsu_valid = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || ld_data !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL rst_after: rv=%b err=%b ld=%h want 1 0 0badf00d", rsp_valid, rsp_err, ld_data);
    end
    exp_data = 32'h0BADF00D;
    tick();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    exp_data   = 32'h0;
    rst_n      = 1'b0;
    lsu_valid  = 1'b0;
    lsu_we     = 1'b0;
    lsu_funct3 = 3'b000;
    lsu_addr   = 32'h0;
    lsu_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    test_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    test_load_word();
    test_store();
    test_illegal();
    test_gnt_stall();
    test_timeout();
    test_reset_mid();

    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
